// File: rtl/channel_matrix_loader.sv
`ifndef WL
`define WL 16
`endif
// Purpose: collects one H (N x N, row-major) plus y (N) word stream into a frame buffer for the Givens stage.
// Latency: out_valid rises 1 cycle after the last word of a frame is accepted.
// Backpressure: in_ready is low while a full frame is held; it returns 1 cycle after out_valid && out_ready.
//
// Ports:
//   clk, rst (async, active low)
//   in_data/in_valid/in_sof/in_ready  : element word stream, H row-major then y
//   Hmatrix_o/Yarray_o/out_valid/out_ready : held frame, element (r,c) at WL*(N*r+c)
//   frame_err                         : one-cycle pulse when in_sof restarts a partial frame
module channel_matrix_loader #(
  parameter int WL = `WL,
  parameter int N  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WL-1:0]     in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [WL*N*N-1:0] Hmatrix_o,
  output logic [WL*N-1:0]   Yarray_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);

  localparam int NH    = N * N;
  localparam int L     = NH + N;
  localparam int IDX_W = $clog2(L);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WL-1:0]    elem_q [L];
  logic [WL-1:0]    elem_d [L];
  logic             frame_err_q, frame_err_d;

  logic             accept;
  logic             restart;
  logic [IDX_W-1:0] wr_idx;

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == FULL);
  assign frame_err = frame_err_q;

  assign accept  = in_valid && in_ready;
  // A start-of-frame marker in the middle of a frame abandons the partial frame
  // and is written as the first element of a new one.
  assign restart = in_sof && (idx_q != '0);
  assign wr_idx  = restart ? '0 : idx_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    elem_d      = elem_q;
    frame_err_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          // H and y share one flat buffer: H(r,c) lands at N*r+c, y[j] at N*N+j.
          for (int k = 0; k < L; k++) begin
            if (wr_idx == IDX_W'(k)) begin
              elem_d[k] = in_data;
            end
          end
          if (restart) begin
            idx_d       = IDX_W'(1);
            frame_err_d = 1'b1;
          end else if (idx_q == IDX_W'(L - 1)) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < L; k++) begin
        elem_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      elem_q      <= elem_d;
    end
  end

  // Buffer is presented directly; contents stay visible after handoff.
  for (genvar k = 0; k < NH; k++) begin : g_h
    assign Hmatrix_o[WL*k +: WL] = elem_q[k];
  end
  for (genvar j = 0; j < N; j++) begin : g_y
    assign Yarray_o[WL*j +: WL] = elem_q[NH+j];
  end

endmodule

// File: doc/channel_matrix_loader.md
CHANNEL_MATRIX_LOADER -- requirements
Module: channel_matrix_loader

Interface
REQ-001 Parameter: WL, default `WL (16), signed word length of every H and y element.
REQ-002 Parameter: N, default 8, real-valued matrix dimension (8 for 4x4 complex MIMO).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: in_data  input  WL  signed element word, stream order H row-major (r=0..N-1, c=0..N-1), then y[0..N-1].
REQ-006 Port: in_valid  input  1  in_data valid this cycle.
REQ-007 Port: in_sof  input  1  start-of-frame marker; qualified by in_valid.
REQ-008 Port: in_ready  output  1  loader accepts a word this cycle.
REQ-009 Port: Hmatrix_o  output  WL*N*N  packed H; element (r,c) at bits [WL*N*r+WL*c +: WL].
REQ-010 Port: Yarray_o  output  WL*N  packed y; y[r] at bits [WL*r +: WL].
REQ-011 Port: out_valid  output  1  complete frame held on Hmatrix_o/Yarray_o.
REQ-012 Port: out_ready  input  1  downstream Givens rotation stage consumes the frame.
REQ-013 Port: frame_err  output  1  one-cycle pulse: in_sof arrived mid-frame.

Function
REQ-014 Word accepted iff in_valid && in_ready on a rising clk edge.
REQ-015 Frame length L = N*N+N words (72 for N=8); word index counter idx width ceil(log2(L)), range 0..L-1.
REQ-016 Word at idx k<N*N stored to H(k/N, k%N); word at idx k>=N*N stored to y[k-N*N]; idx increments per accepted word.
REQ-017 Two-state FSM: LOAD (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1); in_ready and out_valid decoded from registered state only.
REQ-018 LOAD -> FULL on acceptance of word idx L-1; idx wraps to 0 same edge; out_valid high in the cycle after the last word is accepted (latency 1).
REQ-019 FULL -> LOAD on out_valid && out_ready; in_ready high the following cycle; no word accepted in the handoff cycle.
REQ-020 FULL: Hmatrix_o/Yarray_o/idx frozen; in_data/in_sof ignored regardless of in_valid.
REQ-021 Outputs are direct register contents; buffer not cleared on handoff (stale data remains visible, qualified by out_valid=0).
REQ-022 in_sof accepted with idx=0: normal first word, no error.
REQ-023 in_sof accepted with idx!=0: partial frame discarded, word stored as index 0, idx=1, frame_err=1 for exactly the next cycle.
REQ-024 Word accepted at idx=0 without in_sof: accepted as first word (in_sof optional).
REQ-025 in_sof without in_valid: ignored.
REQ-026 Signed values stored bit-exact; no saturation, rounding or sign extension.
REQ-027 out_ready while out_valid=0: ignored.

Reset
REQ-028 rst=0 asynchronously forces: state LOAD, idx=0, all H and y registers 0, out_valid=0, frame_err=0; in_ready=1 while in reset and after release.
REQ-029 Reset mid-frame or in FULL discards the frame; first accepted word after release is index 0.

Verification
REQ-030 Stream words 1..72, in_valid=1 continuous, out_ready=0 -> out_valid rises one cycle after word 72; H(0,0)=1, H(0,7)=8, H(7,7)=64, y[0]=65, y[7]=72; in_ready=0 thereafter.
REQ-031 Hold FULL 10 cycles with in_valid=1, in_data=-5 -> outputs unchanged; then pulse out_ready 1 cycle -> out_valid=0, in_ready=1 next cycle; next frame of -1..-72 loads correctly (H(0,0)=-1 i.e. 16'hFFFF).
REQ-032 Send 20 words, then in_sof with in_data=100 -> frame_err pulse one cycle; 71 more words complete frame with H(0,0)=100; no out_valid after word 20.
REQ-033 Random in_valid gaps (~50% duty) over full frame -> packed output matches row-major file order; out_valid latency 1 after last accepted word.
REQ-034 Assert rst=0 at word 40 for 2 cycles (asynchronous, mid-cycle) -> out_valid=0, all outputs 0 immediately; fresh 72-word frame loads correctly.
REQ-035 Back-to-back frames with out_ready tied 1 -> each frame presented exactly one cycle; one idle in_ready cycle per frame; no word lost or duplicated across 3 frames.
